// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_pkg
// Description : Shared types and constants for the datapath sequencer.
//               Holds the FSM state encoding, the instruction classes,
//               the opcode/op values, the ALUop and vsel codes and the bit
//               positions of every instruction-register field.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

  // Instruction and immediate width. The ISA is fixed at 16 bits.
  localparam int DW = 16;

  // Controller states
  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_EXEC      = 3'd4,
    S_WRITE_RD  = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_t;

  // Decoded instruction classes
  typedef enum logic [2:0] {
    IC_MOV_IMM = 3'd0,
    IC_MOV_REG = 3'd1,
    IC_ADD     = 3'd2,
    IC_CMP     = 3'd3,
    IC_AND     = 3'd4,
    IC_MVN     = 3'd5,
    IC_ILLEGAL = 3'd6
  } iclass_t;

  // Opcode values (IR[15:13])
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // op values (IR[12:11])
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // ALUop codes
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  // Write-back source select
  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  // Instruction-register field positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int OP_HI  = 12;
  localparam int OP_LO  = 11;
  localparam int RN_HI  = 10;
  localparam int RN_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 5;
  localparam int SH_HI  = 4;
  localparam int SH_LO  = 3;
  localparam int RM_HI  = 2;
  localparam int RM_LO  = 0;
  localparam int IMM_HI = 7;

  // Sign-extend the 8-bit immediate to the datapath width
  function automatic logic [DW-1:0] sext8(input logic [7:0] imm);
    return {{(DW-8){imm[7]}}, imm};
  endfunction

endpackage : datapath_pkg
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode
// Description : Purely combinational instruction decoder. Splits the
//               instruction register into its fields, sign-extends imm8 and
//               classifies the instruction.
// Ports       : i_ir      - instruction register contents
//               o_op      - op field IR[12:11]
//               o_rn      - Rn field IR[10:8]
//               o_rd      - Rd field IR[7:5]
//               o_sh      - shift field IR[4:3]
//               o_rm      - Rm field IR[2:0]
//               o_sximm8  - sign-extended IR[7:0]
//               o_iclass  - instruction class
//               o_legal   - 1 when the opcode/op pair is a supported one
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
  import datapath_pkg::*;
(
  input  logic [DW-1:0] i_ir,
  output logic [1:0]    o_op,
  output logic [2:0]    o_rn,
  output logic [2:0]    o_rd,
  output logic [1:0]    o_sh,
  output logic [2:0]    o_rm,
  output logic [DW-1:0] o_sximm8,
  output iclass_t       o_iclass,
  output logic          o_legal
);

  logic [2:0] w_opcode;

  assign w_opcode = i_ir[OPC_HI:OPC_LO];
  assign o_op     = i_ir[OP_HI:OP_LO];
  assign o_rn     = i_ir[RN_HI:RN_LO];
  assign o_rd     = i_ir[RD_HI:RD_LO];
  assign o_sh     = i_ir[SH_HI:SH_LO];
  assign o_rm     = i_ir[RM_HI:RM_LO];
  assign o_sximm8 = sext8(i_ir[IMM_HI:0]);

  always_comb begin
    o_iclass = IC_ILLEGAL;
    if (w_opcode == OPC_MOV) begin
      if (o_op == OP_MOV_IMM)      o_iclass = IC_MOV_IMM;
      else if (o_op == OP_MOV_REG) o_iclass = IC_MOV_REG;
    end else if (w_opcode == OPC_ALU) begin
      // Every op value is defined for the ALU opcode
      case (o_op)
        OP_ADD:  o_iclass = IC_ADD;
        OP_CMP:  o_iclass = IC_CMP;
        OP_AND:  o_iclass = IC_AND;
        default: o_iclass = IC_MVN;
      endcase
    end
  end

  assign o_legal = (o_iclass != IC_ILLEGAL);

endmodule : instr_decode
`default_nettype wire

// File: rtl/datapath_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : datapath_seq_ctrl
// Description : Moore controller sequencing the 16-bit register-file /
//               shifter / ALU datapath one instruction at a time. Holds the
//               instruction register, decodes it and drives all datapath
//               controls as pure decodes of the current state.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               s                  - start (sampled only in WAIT)
//               load, in           - IR capture strobe and instruction word
//               w                  - idle in WAIT, ready for new instruction
//               readnum, writenum  - register-file read / write index
//               write              - register-file write enable
//               loada/b/c, loads   - pipeline and status register enables
//               asel, bsel         - ALU operand selects
//               vsel               - write-back source select
//               ALUop, shift       - ALU operation and shifter control
//               sximm8             - sign-extended IR[7:0]
//               bad_instr          - sticky illegal-instruction flag
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_seq_ctrl
  import datapath_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic          load,
  input  logic [15:0]   in,
  output logic          w,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    vsel,
  output logic [1:0]    ALUop,
  output logic [1:0]    shift,
  output logic [15:0]   sximm8,
  output logic          bad_instr
);

  state_t          r_state;
  state_t          w_next;
  logic [DW-1:0]   r_ir;
  logic            r_bad;

  logic [1:0]      w_op;
  logic [2:0]      w_rn;
  logic [2:0]      w_rd;
  logic [1:0]      w_sh;
  logic [2:0]      w_rm;
  logic [DW-1:0]   w_sximm8;
  iclass_t         w_iclass;
  logic            w_legal;

  instr_decode u_decode (
    .i_ir     (r_ir),
    .o_op     (w_op),
    .o_rn     (w_rn),
    .o_rd     (w_rd),
    .o_sh     (w_sh),
    .o_rm     (w_rm),
    .o_sximm8 (w_sximm8),
    .o_iclass (w_iclass),
    .o_legal  (w_legal)
  );

  // State, instruction register and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_next;
      // IR only loads while idle, so a running instruction keeps its fields
      if (r_state == S_WAIT && load)
        r_ir <= in;
      // A new start clears the flag; an illegal decode sets it on the way out
      if (r_state == S_WAIT && s)
        r_bad <= 1'b0;
      else if (r_state == S_DECODE && !w_legal)
        r_bad <= 1'b1;
    end
  end

  // Next state and Moore output decode
  always_comb begin
    w_next   = r_state;
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = VSEL_C;
    ALUop    = ALU_ADD;
    shift    = 2'b00;

    case (r_state)
      S_WAIT: begin
        w = 1'b1;
        if (s) w_next = S_DECODE;
      end

      S_DECODE: begin
        if (!w_legal) begin
          w_next = S_WAIT;
        end else begin
          case (w_iclass)
            IC_MOV_IMM:        w_next = S_WRITE_IMM;
            IC_MOV_REG,
            IC_MVN:            w_next = S_GET_B;
            default:           w_next = S_GET_A;
          endcase
        end
      end

      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
        w_next  = S_GET_B;
      end

      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
        w_next  = S_EXEC;
      end

      S_EXEC: begin
        shift = w_sh;
        // Single-operand instructions run as 0 op B; MOV reg is 0 + B
        asel  = (w_iclass == IC_MOV_REG) || (w_iclass == IC_MVN);
        ALUop = (w_iclass == IC_MOV_REG) ? ALU_ADD : w_op;
        if (w_iclass == IC_CMP) begin
          loads  = 1'b1;
          w_next = S_WAIT;
        end else begin
          loadc  = 1'b1;
          w_next = S_WRITE_RD;
        end
      end

      S_WRITE_RD: begin
        writenum = w_rd;
        vsel     = VSEL_C;
        write    = 1'b1;
        w_next   = S_WAIT;
      end

      S_WRITE_IMM: begin
        writenum = w_rn;
        vsel     = VSEL_IMM;
        write    = 1'b1;
        w_next   = S_WAIT;
      end

      default: w_next = S_WAIT;
    endcase
  end

  assign sximm8    = w_sximm8;
  assign bad_instr = r_bad;

endmodule : datapath_seq_ctrl
`default_nettype wire

// File: tb/tb_datapath_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_seq_ctrl
// Description : Directed self-checking bench for datapath_seq_ctrl. The
//               Moore controls are packed into one vector and compared
//               cycle by cycle against hand-built expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic        load;
  logic [15:0] instr;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada, loadb, loadc, loads;
  logic        asel, bsel;
  logic [1:0]  vsel;
  logic [1:0]  ALUop;
  logic [1:0]  shift;
  logic [15:0] sximm8;
  logic        bad_instr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  datapath_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .s         (s),
    .load      (load),
    .in        (instr),
    .w         (w),
    .readnum   (readnum),
    .writenum  (writenum),
    .write     (write),
    .loada     (loada),
    .loadb     (loadb),
    .loadc     (loadc),
    .loads     (loads),
    .asel      (asel),
    .bsel      (bsel),
    .vsel      (vsel),
    .ALUop     (ALUop),
    .shift     (shift),
    .sximm8    (sximm8),
    .bad_instr (bad_instr)
  );

  // {w, write, loada, loadb, loadc, loads, asel, bsel, vsel, ALUop, shift,
  //  readnum, writenum}
  logic [19:0] ctl;
  assign ctl = {w, write, loada, loadb, loadc, loads, asel, bsel,
                vsel, ALUop, shift, readnum, writenum};

  function automatic logic [19:0] mk(
    input logic wv, wr, la, lb, lc, ls, as,
    input logic [1:0] vs, alu, sh,
    input logic [2:0] rn, wn);
    return {wv, wr, la, lb, lc, ls, as, 1'b0, vs, alu, sh, rn, wn};
  endfunction

  logic [19:0] IDLE, DEC;

  task automatic check_eq(input string tag, input logic [19:0] got,
                          input logic [19:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare the control vector for the current state, then advance a cycle
  task automatic expc(input string tag, input logic [19:0] exp);
    check_eq(tag, ctl, exp);
    step();
  endtask

  // Load an instruction while idle, then pulse start; returns in DECODE
  task automatic go(input logic [15:0] ins);
    load  = 1'b1;
    instr = ins;
    step();
    load = 1'b0;
    s    = 1'b1;
    step();
    s = 1'b0;
  endtask

  initial begin
    IDLE  = mk(1,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'd0,3'd0);
    DEC   = mk(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'd0,3'd0);
    reset = 1'b1;
    s     = 1'b0;
    load  = 1'b0;
    instr = 16'h0000;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check_eq("rst_ctl", ctl, IDLE);
    check_eq("rst_bad", {19'd0, bad_instr}, 20'd0);
    check_eq("rst_imm", {4'd0, sximm8}, 20'h00000);

    // ADD R2,R1,R0 interrupted by reset in GET_B
    go(16'hA140);
    expc("rA_dec", DEC);
    // load outside WAIT must not disturb IR
    load  = 1'b1;
    instr = 16'hD5FE;
    expc("rA_geta", mk(0,0,1,0,0,0,0, 2'b00,2'b00,2'b00, 3'd1,3'd0));
    load = 1'b0;
    check_eq("rA_geta_imm", {4'd0, sximm8}, 20'h00040);
    check_eq("rA_getb", ctl, mk(0,0,0,1,0,0,0, 2'b00,2'b00,2'b00, 3'd0,3'd0));
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    expc("rA_after_rst", IDLE);
    check_eq("rA_ir_clr", {4'd0, sximm8}, 20'h00000);
    check_eq("rA_still_idle", ctl, IDLE);

    // MOV R0,#7 : 3 edges from start back to WAIT
    go(16'hD007);
    check_eq("m7_imm", {4'd0, sximm8}, 20'h00007);
    expc("m7_dec", DEC);
    expc("m7_wimm", mk(0,1,0,0,0,0,0, 2'b10,2'b00,2'b00, 3'd0,3'd0));
    expc("m7_idle", IDLE);

    // MOV R5,#-2
    go(16'hD5FE);
    check_eq("m5_imm", {4'd0, sximm8}, 20'h0FFFE);
    expc("m5_dec", DEC);
    expc("m5_wimm", mk(0,1,0,0,0,0,0, 2'b10,2'b00,2'b00, 3'd0,3'd5));
    expc("m5_idle", IDLE);

    // ADD R2,R1,R0
    go(16'hA140);
    expc("add_dec",  DEC);
    expc("add_geta", mk(0,0,1,0,0,0,0, 2'b00,2'b00,2'b00, 3'd1,3'd0));
    expc("add_getb", mk(0,0,0,1,0,0,0, 2'b00,2'b00,2'b00, 3'd0,3'd0));
    expc("add_exec", mk(0,0,0,0,1,0,0, 2'b00,2'b00,2'b00, 3'd0,3'd0));
    expc("add_wrd",  mk(0,1,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'd0,3'd2));
    expc("add_idle", IDLE);

    // CMP R1,R0 : no write-back
    go(16'hA900);
    expc("cmp_dec",  DEC);
    expc("cmp_geta", mk(0,0,1,0,0,0,0, 2'b00,2'b00,2'b00, 3'd1,3'd0));
    expc("cmp_getb", mk(0,0,0,1,0,0,0, 2'b00,2'b00,2'b00, 3'd0,3'd0));
    expc("cmp_exec", mk(0,0,0,0,0,1,0, 2'b00,2'b01,2'b00, 3'd0,3'd0));
    expc("cmp_idle", IDLE);

    // MOV R4,R1,LSL#1 with a stray start during EXEC
    go(16'hC089);
    expc("mr_dec",  DEC);
    expc("mr_getb", mk(0,0,0,1,0,0,0, 2'b00,2'b00,2'b00, 3'd1,3'd0));
    s = 1'b1;
    expc("mr_exec", mk(0,0,0,0,1,0,1, 2'b00,2'b00,2'b01, 3'd0,3'd0));
    s = 1'b0;
    expc("mr_wrd",  mk(0,1,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'd0,3'd4));
    expc("mr_idle", IDLE);
    expc("mr_idle2", IDLE);

    // MVN R3,R1
    go(16'hB861);
    expc("mvn_dec",  DEC);
    expc("mvn_getb", mk(0,0,0,1,0,0,0, 2'b00,2'b00,2'b00, 3'd1,3'd0));
    expc("mvn_exec", mk(0,0,0,0,1,0,1, 2'b00,2'b11,2'b00, 3'd0,3'd0));
    expc("mvn_wrd",  mk(0,1,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'd0,3'd3));
    expc("mvn_idle", IDLE);

    // AND R1,R0,R2
    go(16'hB022);
    expc("and_dec",  DEC);
    expc("and_geta", mk(0,0,1,0,0,0,0, 2'b00,2'b00,2'b00, 3'd0,3'd0));
    expc("and_getb", mk(0,0,0,1,0,0,0, 2'b00,2'b00,2'b00, 3'd2,3'd0));
    expc("and_exec", mk(0,0,0,0,1,0,0, 2'b00,2'b10,2'b00, 3'd0,3'd0));
    expc("and_wrd",  mk(0,1,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'd0,3'd1));
    expc("and_idle", IDLE);

    // Illegal instruction: 2 edges back to WAIT, flag is sticky
    go(16'hE000);
    check_eq("ill_bad_dec", {19'd0, bad_instr}, 20'd0);
    expc("ill_dec", DEC);
    check_eq("ill_idle", ctl, IDLE);
    check_eq("ill_bad_set", {19'd0, bad_instr}, 20'd1);
    step();
    check_eq("ill_bad_held", {19'd0, bad_instr}, 20'd1);
    go(16'hD007);
    check_eq("ill_bad_clr", {19'd0, bad_instr}, 20'd0);
    expc("ill_next_dec", DEC);
    expc("ill_next_wimm", mk(0,1,0,0,0,0,0, 2'b10,2'b00,2'b00, 3'd0,3'd0));
    expc("ill_next_idle", IDLE);

    // Back-to-back: start held high restarts straight from WAIT
    load  = 1'b1;
    instr = 16'hD5FE;
    step();
    load = 1'b0;
    s    = 1'b1;
    step();
    expc("b2b_dec1",  DEC);
    expc("b2b_wimm1", mk(0,1,0,0,0,0,0, 2'b10,2'b00,2'b00, 3'd0,3'd5));
    expc("b2b_idle1", IDLE);
    s = 1'b0;
    expc("b2b_dec2",  DEC);
    expc("b2b_wimm2", mk(0,1,0,0,0,0,0, 2'b10,2'b00,2'b00, 3'd0,3'd5));
    expc("b2b_idle2", IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_datapath_seq_ctrl
`default_nettype wire
